// File: rtl/msg_gate_if.sv
`default_nettype none
// ============================================================================
// Module   : msg_gate_if
// Brief    : RX word stream in, destination data/length FIFO writes out.
// Revision : 1.0 - initial release
// ============================================================================
interface msg_gate_if #(
    parameter int DW     = 16,
    parameter int DST_AW = 9
);
    logic [DW-1:0]     P_DATA_IN;
    logic              P_ENA_IN;
    logic [DST_AW-1:0] USED;
    logic [DW-1:0]     P_DATA_OUT;
    logic              P_ENA_OUT;
    logic [8:0]        MSG_LEN;
    logic              WR_REQ_LEN;
    logic              TYPE_VER_NOW;

    modport master (
        output P_DATA_IN, P_ENA_IN, USED,
        input  P_DATA_OUT, P_ENA_OUT, MSG_LEN, WR_REQ_LEN, TYPE_VER_NOW
    );

    modport slave (
        input  P_DATA_IN, P_ENA_IN, USED,
        output P_DATA_OUT, P_ENA_OUT, MSG_LEN, WR_REQ_LEN, TYPE_VER_NOW
    );
endinterface
`default_nettype wire

// File: rtl/msg_gate.sv
`default_nettype none
// ============================================================================
// Module   : msg_gate
// Brief    : Buffers 0x55AA-framed command messages whole and commits them to
//            the destination FIFO only if they fit. Define
//            MSG_GATE_CHKSUM_VERIFY_EN to also drop on checksum mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module msg_gate #(
    parameter int          DW     = 16,
    parameter int          BUF_AW = 9,
    parameter int          DST_AW = 9,
    parameter logic [15:0] PREFIX = 16'h55AA
) (
    input  logic       RST,
    input  logic       RX_CLK,
    msg_gate_if.slave  bus,
    output logic [7:0] MSG_CNT,
    output logic [7:0] DROP_CNT,
    output logic [2:0] STATE_MON
);

    localparam int c_MW = (DST_AW > BUF_AW) ? ((DST_AW > 9) ? DST_AW : 9)
                                            : ((BUF_AW > 9) ? BUF_AW : 9);
    localparam int               c_NW       = c_MW + 2;
    localparam logic [c_NW-1:0]  c_CAP      = c_NW'((1 << DST_AW) - 1);
    localparam logic [15:0]      c_CMD_VER  = 16'h0140;
    localparam logic [15:0]      c_CMD_BULK = 16'h0300;

    typedef enum logic [2:0] {
        S_HUNT = 3'd0,
        S_CMD  = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    state_t            r_state;
    logic [DW-1:0]     r_buf [0:(1 << BUF_AW)-1];
    logic [BUF_AW-1:0] r_wr_ptr;
    logic [BUF_AW-1:0] r_rd_ptr;
    logic [BUF_AW-1:0] r_commit_ptr;
    logic [BUF_AW-1:0] r_mark;
    logic              r_ovf;
    logic              r_has_len;
    logic              r_has_chk;
    logic              r_is_ver;
    logic [7:0]        r_data_len;
    logic [7:0]        r_cnt;
    logic [DW-1:0]     r_data_out;
    logic              r_ena_out;
    logic [8:0]        r_msg_len;
    logic              r_wr_req_len;
    logic              r_type_ver;
    logic [7:0]        r_msg_cnt;
    logic [7:0]        r_drop_cnt;

    state_t            w_next;
    logic [15:0]       w_word;
    logic [7:0]        w_fixed_len;
    logic              w_cur_has_len;
    logic              w_cur_has_chk;
    logic              w_cur_is_ver;
    logic [7:0]        w_cur_dlen;
    logic              w_accept;
    logic [BUF_AW-1:0] w_wr_inc;
    logic              w_full;
    logic              w_write;
    logic              w_last;
    logic              w_end;
    logic [8:0]        w_msg_len;
    logic [BUF_AW-1:0] w_pending;
    logic [c_NW-1:0]   w_need;
    logic              w_ovf_msg;
    logic              w_chk_ok;
    logic              w_commit;
    logic              w_rd_go;

    // Header fields "as of this word": CMD/LEN words override the latched copy
    always_comb begin
        w_word        = bus.P_DATA_IN[15:0];
        w_fixed_len   = 8'd0;
        w_cur_has_len = r_has_len;
        w_cur_has_chk = r_has_chk;
        w_cur_is_ver  = r_is_ver;
        w_cur_dlen    = r_data_len;
        w_next        = r_state;
        w_last        = 1'b0;

        case (w_word)
            c_CMD_VER:  w_fixed_len = 8'd2;
            c_CMD_BULK: w_fixed_len = 8'd252;
            default:    w_fixed_len = 8'd0;
        endcase

        if (r_state == S_CMD) begin
            w_cur_has_len = w_word[0];
            w_cur_has_chk = w_word[1];
            w_cur_is_ver  = (w_word == c_CMD_VER);
            w_cur_dlen    = w_word[0] ? 8'd0 : w_fixed_len;
        end else if (r_state == S_LEN) begin
            w_cur_dlen    = w_word[7:0];
        end

        case (r_state)
            S_HUNT: begin
                if (w_word == PREFIX) w_next = S_CMD;
            end
            S_CMD, S_LEN: begin
                if ((r_state == S_CMD) && w_word[0]) begin
                    w_next = S_LEN;
                end else if (w_cur_dlen != 8'd0) begin
                    w_next = S_DATA;
                end else if (w_cur_has_chk) begin
                    w_next = S_CHK;
                end else begin
                    w_next = S_HUNT;
                    w_last = 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == 8'd1) begin
                    if (r_has_chk) begin
                        w_next = S_CHK;
                    end else begin
                        w_next = S_HUNT;
                        w_last = 1'b1;
                    end
                end
            end
            S_CHK: begin
                w_next = S_HUNT;
                w_last = 1'b1;
            end
            default: w_next = S_HUNT;
        endcase
    end

    assign w_accept  = bus.P_ENA_IN && ((r_state != S_HUNT) || (w_word == PREFIX));
    assign w_wr_inc  = r_wr_ptr + BUF_AW'(1);
    assign w_full    = (w_wr_inc == r_rd_ptr);
    assign w_write   = w_accept && !w_full;
    assign w_end     = bus.P_ENA_IN && w_last;
    assign w_msg_len = 9'd2 + 9'(w_cur_has_len) + 9'(w_cur_dlen) + 9'(w_cur_has_chk);
    assign w_rd_go   = (r_rd_ptr != r_commit_ptr);

    // Committed-but-undrained words still count against destination space
    assign w_pending = r_commit_ptr - r_rd_ptr;
    assign w_need    = c_NW'(bus.USED) + c_NW'(w_pending) + c_NW'(w_msg_len);
    assign w_ovf_msg = ((r_state != S_HUNT) && r_ovf) || (w_accept && w_full);
    assign w_commit  = w_end && (w_need <= c_CAP) && !w_ovf_msg && w_chk_ok;

`ifdef MSG_GATE_CHKSUM_VERIFY_EN
    logic [15:0] r_chk;

    always_ff @(posedge RX_CLK or negedge RST) begin
        if (!RST) begin
            r_chk <= 16'd0;
        end else if (bus.P_ENA_IN) begin
            if (r_state == S_CMD) begin
                r_chk <= w_word;
            end else if ((r_state == S_LEN) || (r_state == S_DATA)) begin
                r_chk <= r_chk + w_word;
            end
        end
    end

    assign w_chk_ok = (r_state != S_CHK) || (w_word == r_chk);
`else
    assign w_chk_ok = 1'b1;
`endif

    always_ff @(posedge RX_CLK) begin
        if (w_write) r_buf[r_wr_ptr] <= bus.P_DATA_IN;
    end

    always_ff @(posedge RX_CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= S_HUNT;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_commit_ptr <= '0;
            r_mark       <= '0;
            r_ovf        <= 1'b0;
            r_has_len    <= 1'b0;
            r_has_chk    <= 1'b0;
            r_is_ver     <= 1'b0;
            r_data_len   <= 8'd0;
            r_cnt        <= 8'd0;
            r_data_out   <= '0;
            r_ena_out    <= 1'b0;
            r_msg_len    <= 9'd0;
            r_wr_req_len <= 1'b0;
            r_type_ver   <= 1'b0;
            r_msg_cnt    <= 8'd0;
            r_drop_cnt   <= 8'd0;
        end else begin
            r_wr_req_len <= 1'b0;
            r_type_ver   <= 1'b0;
            r_ena_out    <= w_rd_go;
            if (w_rd_go) begin
                r_data_out <= r_buf[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + BUF_AW'(1);
            end

            if (bus.P_ENA_IN) begin
                r_state    <= w_next;
                r_has_len  <= w_cur_has_len;
                r_has_chk  <= w_cur_has_chk;
                r_is_ver   <= w_cur_is_ver;
                r_data_len <= w_cur_dlen;
                if ((r_state == S_CMD) || (r_state == S_LEN)) begin
                    r_cnt <= w_cur_dlen;
                end else if (r_state == S_DATA) begin
                    r_cnt <= r_cnt - 8'd1;
                end
            end

            if (w_accept) begin
                r_ovf <= w_ovf_msg;
                if (r_state == S_HUNT) r_mark <= r_wr_ptr;
            end

            // A committed message never overflowed, so its last word was written
            if (w_end) begin
                if (w_commit) begin
                    r_wr_ptr     <= w_wr_inc;
                    r_commit_ptr <= w_wr_inc;
                    r_msg_len    <= w_msg_len;
                    r_wr_req_len <= 1'b1;
                    r_type_ver   <= w_cur_is_ver;
                    r_msg_cnt    <= r_msg_cnt + 8'd1;
                end else begin
                    r_wr_ptr <= r_mark;
                    if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end else if (w_write) begin
                r_wr_ptr <= w_wr_inc;
            end
        end
    end

    assign bus.P_DATA_OUT   = r_data_out;
    assign bus.P_ENA_OUT    = r_ena_out;
    assign bus.MSG_LEN      = r_msg_len;
    assign bus.WR_REQ_LEN   = r_wr_req_len;
    assign bus.TYPE_VER_NOW = r_type_ver;
    assign MSG_CNT          = r_msg_cnt;
    assign DROP_CNT         = r_drop_cnt;
    assign STATE_MON        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_msg_gate.sv
`default_nettype none
// ============================================================================
// Module   : tb_msg_gate
// Brief    : Directed self-checking bench for msg_gate.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msg_gate;

`ifdef MSG_GATE_CHKSUM_VERIFY_EN
    localparam bit c_VERIFY = 1'b1;
`else
    localparam bit c_VERIFY = 1'b0;
`endif

    logic       RST;
    logic       RX_CLK;
    logic [7:0] MSG_CNT;
    logic [7:0] DROP_CNT;
    logic [2:0] STATE_MON;

    msg_gate_if #(.DW(16), .DST_AW(9)) bus ();

    msg_gate #(
        .DW(16), .BUF_AW(9), .DST_AW(9), .PREFIX(16'h55AA)
    ) dut (
        .RST       (RST),
        .RX_CLK    (RX_CLK),
        .bus       (bus),
        .MSG_CNT   (MSG_CNT),
        .DROP_CNT  (DROP_CNT),
        .STATE_MON (STATE_MON)
    );

    initial RX_CLK = 1'b0;
    always #5 RX_CLK = ~RX_CLK;

    int          cyc = 0;
    logic [15:0] out_q [$];
    logic [8:0]  len_q [$];
    int          wr_cyc_q [$];
    int          burst_q [$];
    int          ver_cnt = 0;
    int          used_m = 0;
    bit          prev_ena = 1'b0;
    bit          track_used;
    logic [8:0]  used_set;

    // Undrained destination: its fill level grows with every word written
    assign bus.USED = track_used ? 9'(used_m) : used_set;

    always @(posedge RX_CLK) cyc <= cyc + 1;

    always @(negedge RX_CLK) begin
        if (bus.P_ENA_OUT) out_q.push_back(bus.P_DATA_OUT);
        if (bus.P_ENA_OUT && !prev_ena) burst_q.push_back(cyc);
        prev_ena <= bus.P_ENA_OUT;
        if (bus.WR_REQ_LEN) begin
            len_q.push_back(bus.MSG_LEN);
            wr_cyc_q.push_back(cyc);
        end
        if (bus.TYPE_VER_NOW) ver_cnt <= ver_cnt + 1;
        if (!track_used)        used_m <= 0;
        else if (bus.P_ENA_OUT) used_m <= used_m + 1;
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          last_n;
    int          exp_wr = 0;
    int          exp_msg = 0;
    int          exp_drop = 0;
    int          out_rd = 0;
    int          ex_rd = 0;
    int          v0;
    logic [15:0] cur_q [$];
    logic [15:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] w);
        bus.P_DATA_IN = w;
        bus.P_ENA_IN  = 1'b1;
        last_n        = cyc;
        cur_q.push_back(w);
        @(negedge RX_CLK);
    endtask

    task automatic idle(input int n);
        bus.P_ENA_IN = 1'b0;
        repeat (n) @(negedge RX_CLK);
    endtask

    task automatic finish_msg(input bit keep);
        if (keep) begin
            foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
            exp_wr++;
            exp_msg++;
        end else begin
            exp_drop++;
        end
        cur_q.delete();
    endtask

    // 259 words: prefix, cmd 0x0003 (len+chk), len 0xFF, 255 data, checksum
    task automatic send_long(input logic [15:0] base);
        logic [15:0] s;
        s = 16'h0003 + 16'h00FF;
        send(16'h55AA);
        send(16'h0003);
        send(16'h00FF);
        for (int i = 0; i < 255; i++) begin
            send(base + 16'(i));
            s = s + base + 16'(i);
        end
        send(s);
    endtask

    task automatic check_out(input string tag);
        chk({tag, " out count"}, out_q.size() - out_rd, exp_q.size() - ex_rd);
        for (int k = 0; (out_rd + k < out_q.size()) && (ex_rd + k < exp_q.size()); k++)
            chk({tag, " out word"}, 32'(out_q[out_rd + k]), 32'(exp_q[ex_rd + k]));
        out_rd = out_q.size();
        ex_rd  = exp_q.size();
        chk({tag, " wr_req count"}, len_q.size(), exp_wr);
        chk({tag, " MSG_CNT"}, 32'(MSG_CNT), exp_msg);
        chk({tag, " DROP_CNT"}, 32'(DROP_CNT), exp_drop);
    endtask

    initial begin
        RST           = 1'b0;
        bus.P_DATA_IN = 16'h0000;
        bus.P_ENA_IN  = 1'b0;
        used_set      = 9'd0;
        track_used    = 1'b0;
        repeat (3) @(negedge RX_CLK);
        chk("reset P_ENA_OUT",    32'(bus.P_ENA_OUT), 0);
        chk("reset P_DATA_OUT",   32'(bus.P_DATA_OUT), 0);
        chk("reset MSG_LEN",      32'(bus.MSG_LEN), 0);
        chk("reset WR_REQ_LEN",   32'(bus.WR_REQ_LEN), 0);
        chk("reset TYPE_VER_NOW", 32'(bus.TYPE_VER_NOW), 0);
        chk("reset MSG_CNT",      32'(MSG_CNT), 0);
        chk("reset DROP_CNT",     32'(DROP_CNT), 0);
        chk("reset STATE_MON",    32'(STATE_MON), 0);
        RST = 1'b1;
        @(negedge RX_CLK);

        // A: len+chk message, checksum 0303+0003+1+2+3 = 030C
        send(16'h55AA); chk("A state CMD", 32'(STATE_MON), 1);
        send(16'h0303); chk("A state LEN", 32'(STATE_MON), 2);
        send(16'h0003); chk("A state DATA", 32'(STATE_MON), 3);
        send(16'h0001);
        send(16'h0002);
        send(16'h0003); chk("A state CHK", 32'(STATE_MON), 4);
        send(16'h030C); chk("A state HUNT", 32'(STATE_MON), 0);
        finish_msg(1'b1);
        idle(12);
        chk("A WR_REQ_LEN cycle", wr_cyc_q[wr_cyc_q.size() - 1], last_n + 1);
        chk("A first out cycle", burst_q[burst_q.size() - 1], last_n + 2);
        chk("A MSG_LEN", 32'(len_q[len_q.size() - 1]), 7);
        check_out("A");

        // B: wrong checksum, kept only when verification is off
        send(16'h55AA); send(16'h0303); send(16'h0003);
        send(16'h0001); send(16'h0002); send(16'h0003); send(16'h030D);
        finish_msg(!c_VERIFY);
        idle(12);
        check_out("B");

        // Free-space boundary against USED with nothing pending
        used_set = 9'd508;
        send(16'h55AA); send(16'hFF00); finish_msg(1'b1);
        idle(6);
        chk("USED508 MSG_LEN", 32'(len_q[len_q.size() - 1]), 2);
        used_set = 9'd509;
        send(16'h55AA); send(16'hFF00); finish_msg(1'b1);
        idle(6);
        used_set = 9'd510;
        send(16'h55AA); send(16'hFF00); finish_msg(1'b0);
        idle(6);
        check_out("USED");
        used_set = 9'd0;

        // Back-to-back: version message then short message
        v0 = ver_cnt;
        send(16'h55AA); send(16'h0140); send(16'h1111); send(16'h2222);
        finish_msg(1'b1);
        send(16'h55AA); send(16'hFF00);
        finish_msg(1'b1);
        idle(12);
        chk("B2B TYPE_VER pulses", ver_cnt - v0, 1);
        chk("B2B MSG_LEN 1st", 32'(len_q[len_q.size() - 2]), 4);
        chk("B2B MSG_LEN 2nd", 32'(len_q[len_q.size() - 1]), 2);
        check_out("B2B");

        // Two 259-word messages into an undrained destination
        track_used = 1'b1;
        send_long(16'h1000); finish_msg(1'b1);
        send_long(16'h2000); finish_msg(1'b0);
        idle(280);
        chk("LONG MSG_LEN", 32'(len_q[len_q.size() - 1]), 259);
        check_out("LONG");
        track_used = 1'b0;
        idle(2);

        // Third long message wraps the buffer pointers
        send_long(16'h3000); finish_msg(1'b1);
        idle(280);
        check_out("WRAP");

        // Reset in the middle of a data phase
        send(16'h55AA); send(16'h0140); send(16'h1111);
        chk("MIDRST state DATA", 32'(STATE_MON), 3);
        cur_q.delete();
        bus.P_ENA_IN = 1'b0;
        RST = 1'b0;
        @(negedge RX_CLK);
        chk("MIDRST STATE_MON",  32'(STATE_MON), 0);
        chk("MIDRST MSG_CNT",    32'(MSG_CNT), 0);
        chk("MIDRST DROP_CNT",   32'(DROP_CNT), 0);
        chk("MIDRST MSG_LEN",    32'(bus.MSG_LEN), 0);
        chk("MIDRST P_DATA_OUT", 32'(bus.P_DATA_OUT), 0);
        chk("MIDRST P_ENA_OUT",  32'(bus.P_ENA_OUT), 0);
        RST      = 1'b1;
        exp_msg  = 0;
        exp_drop = 0;
        @(negedge RX_CLK);
        send(16'h55AA); send(16'hFF00); finish_msg(1'b1);
        idle(8);
        chk("POSTRST MSG_LEN", 32'(len_q[len_q.size() - 1]), 2);
        check_out("POSTRST");
        chk("total TYPE_VER pulses", ver_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
